// File: rtl/adder_fifo_pkg.sv
// Shared defaults and entry layout for the adder result FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adder_fifo_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int DEPTH_DEFAULT = 4;

    // One buffered adder result at the default data width; carry sits above sum
    typedef struct packed {
        logic                     carry;
        logic [WIDTH_DEFAULT-1:0] sum;
    } result_t;

endpackage

// File: rtl/adder_fifo_mem.sv
// Result storage array: one synchronous write port, one asynchronous read port.
// Latency: written entry readable the cycle after the write edge.
// Backpressure: none; the caller guarantees it never overwrites a live entry.
module adder_fifo_mem #(
    parameter int DW    = 33,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset; occupancy tracking decides what is valid
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/adder_result_fifo.sv
// First-word-fall-through buffer capturing {carry, sum} results from the pipeline adder.
// Latency: 1 cycle from accepted push to out_valid; pops are combinational on out_ready.
// Backpressure: in_allow drops when full, from state only (no path from out_ready).
// Optional: define ADDER_FIFO_STATS_EN to add accepted_cnt / carry_seen outputs.
module adder_result_fifo
    import adder_fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_carry,
    output logic             in_allow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic [AW:0]      count
`ifdef ADDER_FIFO_STATS_EN
    ,
    output logic [15:0]      accepted_cnt,
    output logic             carry_seen
`endif
);

    // Same layout as result_t, but sized by this instance's WIDTH
    typedef struct packed {
        logic             carry;
        logic [WIDTH-1:0] sum;
    } entry_t;

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    logic   push;
    logic   pop;
    logic   wr_en;
    entry_t wr_entry;
    entry_t rd_entry;

    assign in_allow  = (count_q != CNT_FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_allow;
    assign pop       = out_valid & out_ready;
    // A push coinciding with flush/reset is dropped, so it must not land in storage either
    assign wr_en     = push & ~flush & ~rst;

    assign wr_entry.carry = in_carry;
    assign wr_entry.sum   = in_sum;

    adder_fifo_mem #(
        .DW    ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_dat  (wr_entry),
        .rd_addr (rd_ptr_q),
        .rd_dat  (rd_entry)
    );

    assign out_sum   = rd_entry.sum;
    assign out_carry = rd_entry.carry;
    assign count     = count_q;

    // Next pointer/occupancy: flush wipes everything, otherwise advance on push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/occupancy registers; reset takes priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef ADDER_FIFO_STATS_EN
    logic [15:0] accepted_cnt_q, accepted_cnt_d;
    logic        carry_seen_q,   carry_seen_d;

    // Statistics follow entries that actually get stored; flush leaves them alone
    always_comb begin
        accepted_cnt_d = accepted_cnt_q;
        carry_seen_d   = carry_seen_q;
        if (wr_en) begin
            if (accepted_cnt_q != 16'hFFFF) accepted_cnt_d = accepted_cnt_q + 16'd1;
            if (in_carry)                   carry_seen_d   = 1'b1;
        end
    end

    // Statistics registers, cleared by reset only
    always_ff @(posedge clk) begin
        if (rst) begin
            accepted_cnt_q <= '0;
            carry_seen_q   <= 1'b0;
        end else begin
            accepted_cnt_q <= accepted_cnt_d;
            carry_seen_q   <= carry_seen_d;
        end
    end

    assign accepted_cnt = accepted_cnt_q;
    assign carry_seen   = carry_seen_q;
`endif

endmodule

// File: tb/tb_adder_result_fifo.sv
// Directed plus randomized bench for adder_result_fifo against a queue-based reference.
// Latency: model state updated at each rising edge, DUT sampled 1 time unit later.
// Backpressure: model accepts only while it holds fewer than DEPTH entries.
module tb_adder_result_fifo;
    import adder_fifo_pkg::*;

    localparam int WIDTH = WIDTH_DEFAULT;
    localparam int DEPTH = DEPTH_DEFAULT;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_sum = '0;
    logic             in_carry = 1'b0;
    logic             in_allow;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic [AW:0]      count;
`ifdef ADDER_FIFO_STATS_EN
    logic [15:0]      accepted_cnt;
    logic             carry_seen;
`endif

    adder_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .in_allow  (in_allow),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .count     (count)
`ifdef ADDER_FIFO_STATS_EN
        ,
        .accepted_cnt (accepted_cnt),
        .carry_seen   (carry_seen)
`endif
    );

    always #5 clk = ~clk;

    // Reference: an ordered queue of stored results plus the two statistics
    result_t     mq[$];
    logic [15:0] m_acc = '0;
    logic        m_cs  = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        check("count", 64'(count), 64'(mq.size()));
        check("in_allow", 64'(in_allow), 64'(mq.size() != DEPTH));
        check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("out_sum", 64'(out_sum), 64'(mq[0].sum));
            check("out_carry", 64'(out_carry), 64'(mq[0].carry));
        end
`ifdef ADDER_FIFO_STATS_EN
        check("accepted_cnt", 64'(accepted_cnt), 64'(m_acc));
        check("carry_seen", 64'(carry_seen), 64'(m_cs));
`endif
    endtask

    // Advance one clock, updating the reference from the inputs seen at the edge
    task automatic step();
        bit      do_push;
        bit      do_pop;
        result_t e;
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = out_ready && (mq.size() > 0);
        e.carry = in_carry;
        e.sum   = in_sum;
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
        if (rst) begin
            m_acc = '0;
            m_cs  = 1'b0;
        end else if (do_push && !flush) begin
            if (m_acc != 16'hFFFF) m_acc = m_acc + 16'd1;
            if (e.carry) m_cs = 1'b1;
        end
        #1;
        check_state();
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] s, input logic c, input logic r);
        in_valid  = v;
        in_sum    = s;
        in_carry  = c;
        out_ready = r;
    endtask

    initial begin
        // Reset then idle
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        check("rst_count", 64'(count), 64'd0);
        check("rst_allow", 64'(in_allow), 64'd1);
        check("rst_valid", 64'(out_valid), 64'd0);

        // Single transfer
        drive(1'b1, 32'h0000_00FF, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_sum", 64'(out_sum), 64'h0000_00FF);
        check("single_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("single_drained", 64'(count), 64'd0);

        // Fill to full, then a held 5th value must be refused
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, WIDTH'(i), i[0], 1'b0);
            step();
        end
        check("full_count", 64'(count), 64'd4);
        check("full_allow", 64'(in_allow), 64'd0);
        drive(1'b1, 32'd5, 1'b1, 1'b0);
        step();
        check("full_hold", 64'(count), 64'd4);
        // Drain in order, carry preserved
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0);
            check("drain_sum", 64'(out_sum), 64'(i));
            check("drain_carry", 64'(out_carry), 64'(i % 2));
            out_ready = 1'b1;
            step();
        end
        check("drain_empty", 64'(count), 64'd0);

        // Simultaneous push/pop at occupancy 2, crossing the pointer wrap
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h11, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'hA + WIDTH'(i), i[0], 1'b1);
            step();
            check("pp_count", 64'(count), 64'd2);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        step();
        step();
        check("pp_empty", 64'(count), 64'd0);

        // Flush mid-stream with a coincident push of 9
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h20 + WIDTH'(i), 1'b0, 1'b0);
            step();
        end
        check("pre_flush", 64'(count), 64'd3);
        drive(1'b1, 32'd9, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        step();
        check("flush_no9", 64'(out_valid), 64'd0);

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 6), $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
            flush = ($urandom_range(0, 39) == 0);
            step();
        end
        flush = 1'b0;

`ifdef ADDER_FIFO_STATS_EN
        // Statistics: three pushes, second with carry, then a flush must not clear them
        drive(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h30 + WIDTH'(i), (i == 1), 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        check("stats_acc", 64'(accepted_cnt), 64'd3);
        check("stats_carry", 64'(carry_seen), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("stats_acc_flush", 64'(accepted_cnt), 64'd3);
        check("stats_carry_flush", 64'(carry_seen), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
